// File: rtl/fetch_decode_if.sv
// Bus bundle for fetch_decode: the instruction-memory byte port, redirect input and decoded-instruction handshake.
// dbg_state mirrors the FSM state so that checkers can bind to it.
interface fetch_decode_if;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic [31:0] ope;
  logic [31:0] immidiate_data;
  logic [31:0] instr_pc;
  logic [2:0]  instr_len;
  logic        dec_valid;
  logic        dec_ready;
  logic        illegal;
  logic [2:0]  dbg_state;

  modport master (
    output mem_rd, mem_addr, ope, immidiate_data, instr_pc, instr_len,
           dec_valid, illegal, dbg_state,
    input  mem_rvalid, mem_rdata, pc_load, pc_load_addr, dec_ready
  );

  modport slave (
    input  mem_rd, mem_addr, ope, immidiate_data, instr_pc, instr_len,
           dec_valid, illegal, dbg_state,
    output mem_rvalid, mem_rdata, pc_load, pc_load_addr, dec_ready
  );
endinterface

// File: rtl/fetch_decode.sv
// Byte-serial instruction fetch and decode for a small x86-like subset, with one memory read in flight.
// Defining FETCH_DECODE_ILLEGAL_TRAP_EN makes unknown opcodes halt with the illegal flag set.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset_n,
  fetch_decode_if.master bus
);
  // Handshake: an instruction transfers in the cycle dec_valid && dec_ready are both high;
  // while dec_valid is high, ope, immidiate_data, instr_pc and instr_len are held stable.
  localparam logic [2:0] ST_FETCH_OP    = 3'd0;
  localparam logic [2:0] ST_FETCH_MODRM = 3'd1;
  localparam logic [2:0] ST_FETCH_IMM   = 3'd2;
  localparam logic [2:0] ST_ISSUE       = 3'd3;
  localparam logic [2:0] ST_HALT        = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic        r_rd;
  logic        r_pend;
  logic        r_drop;
  logic [1:0]  r_cnt;
  logic [31:0] r_ope;
  logic [31:0] r_imm;
  logic [31:0] r_instr_pc;
  logic [2:0]  r_len;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
  logic        r_illegal;
`endif

  logic w_fetching;
  logic w_accept;
  logic w_redirect;

  assign w_fetching = (r_state == ST_FETCH_OP) || (r_state == ST_FETCH_MODRM) ||
                      (r_state == ST_FETCH_IMM);
  // A response belongs to this instruction only if a read is in flight and was not orphaned by a redirect.
  assign w_accept   = bus.mem_rvalid && r_pend && !r_drop;
  assign w_redirect = bus.pc_load && (r_state != ST_HALT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_FETCH_OP;
      r_pc       <= RESET_PC;
      r_rd       <= 1'b0;
      r_pend     <= 1'b0;
      r_drop     <= 1'b0;
      r_cnt      <= 2'd0;
      r_ope      <= 32'h0;
      r_imm      <= 32'h0;
      r_instr_pc <= 32'h0;
      r_len      <= 3'd0;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_rd <= 1'b0;
      if (bus.mem_rvalid) begin
        r_pend <= 1'b0;
        r_drop <= 1'b0;
      end
      if (w_redirect) begin
        r_pc    <= bus.pc_load_addr;
        r_state <= ST_FETCH_OP;
        r_cnt   <= 2'd0;
        // The read still in flight will come back for the old stream; swallow it.
        r_drop  <= r_pend && !bus.mem_rvalid;
      end else begin
        if (w_fetching && !r_pend) begin
          r_rd   <= 1'b1;
          r_pend <= 1'b1;
        end
        case (r_state)
          ST_FETCH_OP: begin
            if (w_accept) begin
              r_pc       <= r_pc + 32'd1;
              r_instr_pc <= r_pc;
              r_imm      <= 32'h0;
              r_cnt      <= 2'd0;
              r_ope      <= {bus.mem_rdata, 24'h0};
              case (bus.mem_rdata)
                8'h55, 8'h5d, 8'hc3, 8'h90: begin
                  r_len   <= 3'd1;
                  r_state <= ST_ISSUE;
                end
                8'h89: begin
                  r_len   <= 3'd2;
                  r_state <= ST_FETCH_MODRM;
                end
                8'hb8, 8'he8: begin
                  r_len   <= 3'd5;
                  r_state <= ST_FETCH_IMM;
                end
                default: begin
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
                  r_illegal <= 1'b1;
                  r_len     <= 3'd1;
                  r_state   <= ST_HALT;
`else
                  r_ope   <= 32'h9000_0000;
                  r_len   <= 3'd1;
                  r_state <= ST_ISSUE;
`endif
                end
              endcase
            end
          end
          ST_FETCH_MODRM: begin
            if (w_accept) begin
              r_pc          <= r_pc + 32'd1;
              r_ope[23:16]  <= bus.mem_rdata;
              r_state       <= ST_ISSUE;
            end
          end
          ST_FETCH_IMM: begin
            if (w_accept) begin
              r_pc                        <= r_pc + 32'd1;
              r_imm[{r_cnt, 3'b000} +: 8] <= bus.mem_rdata;
              r_cnt                       <= r_cnt + 2'd1;
              if (r_cnt == 2'd3) r_state <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (bus.dec_ready) r_state <= ST_FETCH_OP;
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign bus.mem_rd         = r_rd;
  assign bus.mem_addr       = r_pc;
  assign bus.ope            = r_ope;
  assign bus.immidiate_data = r_imm;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.instr_len      = r_len;
  assign bus.dec_valid      = (r_state == ST_ISSUE);
  assign bus.dbg_state      = r_state;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
  assign bus.illegal        = r_illegal;
`else
  assign bus.illegal        = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: byte-memory responders with programmable latency drive two instances,
// one at the default reset PC and one starting at 32'hFFFF_FFFF to exercise PC wrap.
module tb_fetch_decode;
  logic clock;
  logic reset_n;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  logic [7:0] mem [0:255];
  int         lat;
  int         rd_count;
  logic       pend_a;
  int         cnt_a;
  logic [31:0] paddr_a;
  logic       pend_b;
  logic [31:0] paddr_b;

  fetch_decode_if bus_a();
  fetch_decode_if bus_b();

  fetch_decode #(.RESET_PC(32'h0000_0000)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFF)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // memory responder for instance A: answers each request after lat cycles
  initial begin
    bus_a.mem_rvalid = 1'b0;
    bus_a.mem_rdata  = 8'h00;
    pend_a = 1'b0;
    cnt_a = 0;
    paddr_a = 32'h0;
    rd_count = 0;
    forever begin
      @(negedge clock);
      bus_a.mem_rvalid = 1'b0;
      if (!reset_n) begin
        pend_a = 1'b0;
      end else begin
        if (pend_a && cnt_a == 0) begin
          bus_a.mem_rvalid = 1'b1;
          bus_a.mem_rdata  = mem[paddr_a[7:0]];
          pend_a = 1'b0;
        end else if (pend_a) begin
          cnt_a = cnt_a - 1;
        end
        if (bus_a.mem_rd) begin
          pend_a   = 1'b1;
          paddr_a  = bus_a.mem_addr;
          cnt_a    = lat - 1;
          rd_count = rd_count + 1;
        end
      end
    end
  end

  // memory responder for instance B: fixed one-cycle latency, c3 at the top address, nop elsewhere
  initial begin
    bus_b.mem_rvalid = 1'b0;
    bus_b.mem_rdata  = 8'h00;
    pend_b = 1'b0;
    paddr_b = 32'h0;
    forever begin
      @(negedge clock);
      bus_b.mem_rvalid = 1'b0;
      if (!reset_n) begin
        pend_b = 1'b0;
      end else begin
        if (pend_b) begin
          bus_b.mem_rvalid = 1'b1;
          bus_b.mem_rdata  = (paddr_b == 32'hFFFF_FFFF) ? 8'hc3 : 8'h90;
          pend_b = 1'b0;
        end
        if (bus_b.mem_rd) begin
          pend_b  = 1'b1;
          paddr_b = bus_b.mem_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag, input logic [31:0] exp_addr);
    for (int i = 0; i < 40; i++) begin
      if (bus_a.mem_rd) break;
      step();
    end
    chk({tag, "_rd"}, 32'(bus_a.mem_rd), 32'd1);
    chk({tag, "_addr"}, bus_a.mem_addr, exp_addr);
  endtask

  task automatic wait_issue(input string tag, input logic [31:0] exp_pc,
                            input logic [2:0] exp_len, input logic [31:0] exp_imm);
    logic [31:0] exp_ope;
    for (int i = 0; i < 60; i++) begin
      if (bus_a.dec_valid) break;
      step();
    end
    exp_ope = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(bus_a.dec_valid), 32'd1);
    chk({tag, "_ope"}, bus_a.ope, exp_ope);
    chk({tag, "_pc"}, bus_a.instr_pc, exp_pc);
    chk({tag, "_len"}, 32'(bus_a.instr_len), 32'(exp_len));
    chk({tag, "_imm"}, bus_a.immidiate_data, exp_imm);
  endtask

  initial begin
    int snap;
    logic seen_valid;
    checks = 0;
    errors = 0;
    lat = 1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h90;
    mem[8'h00] = 8'h55;
    mem[8'h01] = 8'h89; mem[8'h02] = 8'he5;
    mem[8'h03] = 8'h90;
    mem[8'h10] = 8'hb8; mem[8'h11] = 8'h78; mem[8'h12] = 8'h56;
    mem[8'h13] = 8'h34; mem[8'h14] = 8'h12;
    mem[8'h15] = 8'he8; mem[8'h16] = 8'h11; mem[8'h17] = 8'h22;
    mem[8'h18] = 8'h33; mem[8'h19] = 8'h44;
    mem[8'h40] = 8'hc3;
    mem[8'h41] = 8'hff;

    reset_n = 1'b0;
    bus_a.pc_load = 1'b0; bus_a.pc_load_addr = 32'h0; bus_a.dec_ready = 1'b0;
    bus_b.pc_load = 1'b0; bus_b.pc_load_addr = 32'h0; bus_b.dec_ready = 1'b0;
    step();
    step();

    // values held in reset
    chk("rst_mem_rd", 32'(bus_a.mem_rd), 32'd0);
    chk("rst_mem_addr", bus_a.mem_addr, 32'h0);
    chk("rst_ope", bus_a.ope, 32'h0);
    chk("rst_imm", bus_a.immidiate_data, 32'h0);
    chk("rst_instr_pc", bus_a.instr_pc, 32'h0);
    chk("rst_instr_len", 32'(bus_a.instr_len), 32'd0);
    chk("rst_dec_valid", 32'(bus_a.dec_valid), 32'd0);
    chk("rst_illegal", 32'(bus_a.illegal), 32'd0);
    chk("rst_b_mem_addr", bus_b.mem_addr, 32'hFFFF_FFFF);

    // one-byte push at address 0
    reset_n = 1'b1;
    bus_a.dec_ready = 1'b1;
    step();
    chk("first_rd_after_reset", 32'(bus_a.mem_rd), 32'd1);
    wait_rd("t1", 32'h0);
    exp_q.push_back(32'h5500_0000);
    wait_issue("t1", 32'h0, 3'd1, 32'h0);
    step();
    bus_a.dec_ready = 1'b0;
    wait_rd("t1_next", 32'h1);

    // mov with ModRM, consumer stalls four cycles
    exp_q.push_back(32'h89e5_0000);
    wait_issue("t2", 32'h1, 3'd2, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_hold_valid", 32'(bus_a.dec_valid), 32'd1);
      chk("t2_hold_ope", bus_a.ope, 32'h89e5_0000);
    end
    bus_a.dec_ready = 1'b1;
    step();
    bus_a.dec_ready = 1'b0;
    chk("t2_after_accept_valid", 32'(bus_a.dec_valid), 32'd0);
    snap = rd_count;
    for (int i = 0; i < 8; i++) step();
    chk("t2_single_fetch", 32'(rd_count - snap), 32'd1);
    exp_q.push_back(32'h9000_0000);
    wait_issue("t2_nop", 32'h3, 3'd1, 32'h0);

    // redirect coincident with accept, then mov imm32 at 0x10
    bus_a.pc_load = 1'b1;
    bus_a.pc_load_addr = 32'h10;
    bus_a.dec_ready = 1'b1;
    step();
    bus_a.pc_load = 1'b0;
    chk("t3_redirect_valid", 32'(bus_a.dec_valid), 32'd0);
    wait_rd("t3", 32'h10);
    exp_q.push_back(32'hb800_0000);
    wait_issue("t3", 32'h10, 3'd5, 32'h1234_5678);
    step();
    wait_rd("t3_next", 32'h15);
    lat = 4;

    // call interrupted by redirect while immediate byte 2 is in flight
    for (int i = 0; i < 80; i++) begin
      if (bus_a.mem_rd && bus_a.mem_addr == 32'h18) break;
      step();
    end
    chk("t4_imm2_req", bus_a.mem_addr, 32'h18);
    bus_a.pc_load = 1'b1;
    bus_a.pc_load_addr = 32'h40;
    step();
    bus_a.pc_load = 1'b0;
    lat = 1;
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.dec_valid) seen_valid = 1'b1;
      if (bus_a.mem_rd) break;
      step();
    end
    chk("t4_no_issue", 32'(seen_valid), 32'd0);
    wait_rd("t4", 32'h40);
    exp_q.push_back(32'hc300_0000);
    wait_issue("t4_ret", 32'h40, 3'd1, 32'h0);
    step();

    // unknown opcode ff at 0x41
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 40; i++) begin
      if (bus_a.illegal) break;
      step();
    end
    chk("t5_illegal", 32'(bus_a.illegal), 32'd1);
    chk("t5_no_valid", 32'(bus_a.dec_valid), 32'd0);
    snap = rd_count;
    bus_a.pc_load = 1'b1;
    bus_a.pc_load_addr = 32'h80;
    step();
    bus_a.pc_load = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_halt_no_rd", 32'(rd_count - snap), 32'd0);
    chk("t5_halt_illegal", 32'(bus_a.illegal), 32'd1);
`else
    exp_q.push_back(32'h9000_0000);
    wait_issue("t5", 32'h41, 3'd1, 32'h0);
    chk("t5_illegal", 32'(bus_a.illegal), 32'd0);
`endif

    // reset in the middle of a slow fetch
    lat = 5;
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rd", 32'(bus_a.mem_rd), 32'd0);
    chk("t6_rst_addr", bus_a.mem_addr, 32'h0);
    step();
    chk("t6_rst_illegal", 32'(bus_a.illegal), 32'd0);
    reset_n = 1'b1;
    step();
    chk("t6_first_rd", 32'(bus_a.mem_rd), 32'd1);
    chk("t6_first_addr", bus_a.mem_addr, 32'h0);
    exp_q.push_back(32'h5500_0000);
    wait_issue("t6", 32'h0, 3'd1, 32'h0);

    // instance B: top-of-memory wrap
    for (int i = 0; i < 20; i++) begin
      if (bus_b.dec_valid) break;
      step();
    end
    chk("tb_valid", 32'(bus_b.dec_valid), 32'd1);
    chk("tb_ope", bus_b.ope, 32'hc300_0000);
    chk("tb_instr_pc", bus_b.instr_pc, 32'hFFFF_FFFF);
    chk("tb_len", 32'(bus_b.instr_len), 32'd1);
    bus_b.dec_ready = 1'b1;
    step();
    bus_b.dec_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_b.mem_rd) break;
      step();
    end
    chk("tb_next_rd", 32'(bus_b.mem_rd), 32'd1);
    chk("tb_next_addr", bus_b.mem_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
